// File: rtl/memory_access.sv
// Memory-access pipeline stage: byte-lane steering for stores and sign/zero extension for loads
// over a command/ack plus ready data bus. Optional misaligned-access trap: MEM_ALIGN_CHECK_EN.
module memory_access #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int REGNO_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   i_exec_stall,
  input  logic                   i_fetch_stall,
  output logic                   o_mem_stall,
  input  logic [5:0]             i_op,
  input  logic [REGNO_WIDTH-1:0] i_dst_gpr,
  input  logic [DATA_WIDTH-1:0]  i_result,
  input  logic [DATA_WIDTH-1:0]  i_mem_data,
  output logic [ADDR_WIDTH-1:0]  o_dm_addr,
  output logic                   o_dm_rnw,
  output logic                   o_dm_cmd,
  input  logic                   i_dm_ack,
  output logic [DATA_WIDTH-1:0]  o_dm_data,
  output logic [3:0]             o_dm_be,
  input  logic                   i_dm_rdy,
  input  logic [DATA_WIDTH-1:0]  i_dm_data,
  output logic [REGNO_WIDTH-1:0] o_dst_gpr,
  output logic [DATA_WIDTH-1:0]  o_result
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic                   o_addr_err
`endif
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t                 state_q, state_d;
  logic [5:0]             op_q, op_d;
  logic [REGNO_WIDTH-1:0] dst_q, dst_d;
  logic [1:0]             alo_q, alo_d;
  logic [ADDR_WIDTH-1:0]  dm_addr_q, dm_addr_d;
  logic                   dm_rnw_q, dm_rnw_d;
  logic                   dm_cmd_q, dm_cmd_d;
  logic [DATA_WIDTH-1:0]  dm_data_q, dm_data_d;
  logic [3:0]             dm_be_q, dm_be_d;
  logic [REGNO_WIDTH-1:0] dst_gpr_q, dst_gpr_d;
  logic [DATA_WIDTH-1:0]  result_q, result_d;
  logic                   addr_err_q, addr_err_d;

  logic                   core_stall;
  logic                   in_is_mem, in_is_load, mis;
  logic [DATA_WIDTH-1:0]  st_data;
  logic [3:0]             st_be;
  logic [DATA_WIDTH-1:0]  rd_shift, ld_data;
  logic [15:0]            rd_half;
  logic                   q_is_load;

  // Stall is a pure function of state so downstream stages see no input-to-output path.
  assign o_mem_stall = (state_q != IDLE);
  assign core_stall  = i_exec_stall | i_fetch_stall | o_mem_stall;

  always_comb begin
    in_is_load = (i_op == OP_LB) || (i_op == OP_LH) || (i_op == OP_LW) ||
                 (i_op == OP_LBU) || (i_op == OP_LHU);
    in_is_mem  = in_is_load || (i_op == OP_SB) || (i_op == OP_SH) || (i_op == OP_SW);
    q_is_load  = (op_q == OP_LB) || (op_q == OP_LH) || (op_q == OP_LW) ||
                 (op_q == OP_LBU) || (op_q == OP_LHU);
  end

  always_comb begin
    mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    if ((i_op == OP_LH || i_op == OP_LHU || i_op == OP_SH) && i_result[0])
      mis = 1'b1;
    if ((i_op == OP_LW || i_op == OP_SW) && (i_result[1:0] != 2'b00))
      mis = 1'b1;
`endif
  end

  // Store data is replicated across lanes so the byte enables alone pick the target bytes.
  always_comb begin
    st_data = i_mem_data;
    st_be   = 4'b1111;
    case (i_op)
      OP_SB: begin
        st_data = {4{i_mem_data[7:0]}};
        st_be   = 4'b0001 << i_result[1:0];
      end
      OP_SH: begin
        st_data = {2{i_mem_data[15:0]}};
        st_be   = i_result[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_shift = i_dm_data >> {alo_q, 3'b000};
    rd_half  = alo_q[1] ? i_dm_data[31:16] : i_dm_data[15:0];
    case (op_q)
      OP_LB:   ld_data = {{(DATA_WIDTH-8){rd_shift[7]}}, rd_shift[7:0]};
      OP_LBU:  ld_data = {{(DATA_WIDTH-8){1'b0}}, rd_shift[7:0]};
      OP_LH:   ld_data = {{(DATA_WIDTH-16){rd_half[15]}}, rd_half};
      OP_LHU:  ld_data = {{(DATA_WIDTH-16){1'b0}}, rd_half};
      default: ld_data = i_dm_data;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    dst_d      = dst_q;
    alo_d      = alo_q;
    dm_addr_d  = dm_addr_q;
    dm_rnw_d   = dm_rnw_q;
    dm_cmd_d   = dm_cmd_q;
    dm_data_d  = dm_data_q;
    dm_be_d    = dm_be_q;
    dst_gpr_d  = dst_gpr_q;
    result_d   = result_q;
    addr_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!core_stall) begin
          if (in_is_mem && mis) begin
            dst_gpr_d  = '0;
            addr_err_d = 1'b1;
          end else if (in_is_mem) begin
            op_d      = i_op;
            dst_d     = i_dst_gpr;
            alo_d     = i_result[1:0];
            dst_gpr_d = '0;
            dm_cmd_d  = 1'b1;
            dm_addr_d = {i_result[ADDR_WIDTH-1:2], 2'b00};
            dm_rnw_d  = in_is_load;
            dm_data_d = st_data;
            dm_be_d   = st_be;
            state_d   = CMD;
          end else begin
            dst_gpr_d = i_dst_gpr;
            result_d  = i_result;
          end
        end
      end
      CMD: begin
        // A rdy arriving together with ack belongs to no data phase yet and is dropped.
        if (i_dm_ack) begin
          dm_cmd_d = 1'b0;
          state_d  = DATA;
        end
      end
      DATA: begin
        if (i_dm_rdy) begin
          if (q_is_load) begin
            dst_gpr_d = dst_q;
            result_d  = ld_data;
          end else begin
            dst_gpr_d = '0;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      op_q       <= '0;
      dst_q      <= '0;
      alo_q      <= '0;
      dm_addr_q  <= '0;
      dm_rnw_q   <= 1'b0;
      dm_cmd_q   <= 1'b0;
      dm_data_q  <= '0;
      dm_be_q    <= '0;
      dst_gpr_q  <= '0;
      result_q   <= '0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      dst_q      <= dst_d;
      alo_q      <= alo_d;
      dm_addr_q  <= dm_addr_d;
      dm_rnw_q   <= dm_rnw_d;
      dm_cmd_q   <= dm_cmd_d;
      dm_data_q  <= dm_data_d;
      dm_be_q    <= dm_be_d;
      dst_gpr_q  <= dst_gpr_d;
      result_q   <= result_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign o_dm_addr = dm_addr_q;
  assign o_dm_rnw  = dm_rnw_q;
  assign o_dm_cmd  = dm_cmd_q;
  assign o_dm_data = dm_data_q;
  assign o_dm_be   = dm_be_q;
  assign o_dst_gpr = dst_gpr_q;
  assign o_result  = result_q;

`ifdef MEM_ALIGN_CHECK_EN
  assign o_addr_err = addr_err_q;
`else
  logic unused_err;
  assign unused_err = addr_err_q;
`endif

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: vector table of ALU/load/store ops plus hand-written
// sequences for stalls, same-cycle ack/rdy and reset in the middle of an access.
module tb_memory_access;

  logic        clk = 1'b0;
  logic        nrst;
  logic        i_exec_stall, i_fetch_stall;
  logic        o_mem_stall;
  logic [5:0]  i_op;
  logic [4:0]  i_dst_gpr;
  logic [31:0] i_result, i_mem_data;
  logic [31:0] o_dm_addr;
  logic        o_dm_rnw, o_dm_cmd, i_dm_ack;
  logic [31:0] o_dm_data;
  logic [3:0]  o_dm_be;
  logic        i_dm_rdy;
  logic [31:0] i_dm_data;
  logic [4:0]  o_dst_gpr;
  logic [31:0] o_result;
`ifdef MEM_ALIGN_CHECK_EN
  logic        o_addr_err;
`endif

  memory_access dut (
    .clk(clk), .nrst(nrst), .i_exec_stall(i_exec_stall), .i_fetch_stall(i_fetch_stall),
    .o_mem_stall(o_mem_stall), .i_op(i_op), .i_dst_gpr(i_dst_gpr), .i_result(i_result),
    .i_mem_data(i_mem_data), .o_dm_addr(o_dm_addr), .o_dm_rnw(o_dm_rnw), .o_dm_cmd(o_dm_cmd),
    .i_dm_ack(i_dm_ack), .o_dm_data(o_dm_data), .o_dm_be(o_dm_be), .i_dm_rdy(i_dm_rdy),
    .i_dm_data(i_dm_data), .o_dst_gpr(o_dst_gpr), .o_result(o_result)
`ifdef MEM_ALIGN_CHECK_EN
    , .o_addr_err(o_addr_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  dst;
    logic [31:0] res;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          ack_dly;
    int          rdy_dly;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [4:0]  exp_dst;
    logic [31:0] exp_res;
    logic        chk_res;
  } vec_t;

  int tests = 0;
  int fails = 0;
  vec_t vq[$];

  function automatic vec_t mk(logic [5:0] op, logic [4:0] dst, logic [31:0] res,
                              logic [31:0] sdata, logic [31:0] rdata, int ad, int rd,
                              logic [31:0] ea, logic [3:0] ebe, logic [31:0] ew,
                              logic [4:0] ed, logic [31:0] er, logic cr);
    vec_t v;
    v.op = op; v.dst = dst; v.res = res; v.sdata = sdata; v.rdata = rdata;
    v.ack_dly = ad; v.rdy_dly = rd; v.exp_addr = ea; v.exp_be = ebe; v.exp_wdata = ew;
    v.exp_dst = ed; v.exp_res = er; v.chk_res = cr;
    return v;
  endfunction

  function automatic logic is_mem(logic [5:0] op);
    return op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [5:0] op, input logic [4:0] dst, input logic [31:0] res,
                       input logic [31:0] sdata);
    @(negedge clk);
    i_op = op; i_dst_gpr = dst; i_result = res; i_mem_data = sdata;
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input vec_t v);
    i_dm_data = v.rdata;
    issue(v.op, v.dst, v.res, v.sdata);
    if (is_mem(v.op)) begin
      chk("issue_stall", {31'b0, o_mem_stall}, 32'd1);
      chk("issue_cmd", {31'b0, o_dm_cmd}, 32'd1);
      chk("issue_addr", o_dm_addr, v.exp_addr);
      chk("issue_rnw", {31'b0, o_dm_rnw}, {31'b0, (v.op < 6'h28)});
      chk("issue_be", {28'b0, o_dm_be}, {28'b0, v.exp_be});
      if (v.op >= 6'h28) chk("issue_wdata", o_dm_data, v.exp_wdata);
      chk("issue_bubble", {27'b0, o_dst_gpr}, 32'd0);
      @(negedge clk); i_op = 6'h00; i_dst_gpr = 5'd0;
      for (int k = 0; k < v.ack_dly; k++) begin
        @(posedge clk); #1;
        chk("cmd_hold", {31'b0, o_dm_cmd}, 32'd1);
        chk("cmd_addr_hold", o_dm_addr, v.exp_addr);
        chk("cmd_stall", {31'b0, o_mem_stall}, 32'd1);
      end
      @(negedge clk); i_dm_ack = 1'b1;
      @(posedge clk); #1;
      chk("ack_cmd_low", {31'b0, o_dm_cmd}, 32'd0);
      chk("data_stall", {31'b0, o_mem_stall}, 32'd1);
      @(negedge clk); i_dm_ack = 1'b0;
      for (int k = 0; k < v.rdy_dly; k++) begin
        @(posedge clk); #1;
        chk("wait_stall", {31'b0, o_mem_stall}, 32'd1);
      end
      @(negedge clk); i_dm_rdy = 1'b1;
      @(posedge clk); #1;
      chk("done_stall", {31'b0, o_mem_stall}, 32'd0);
      chk("done_dst", {27'b0, o_dst_gpr}, {27'b0, v.exp_dst});
      if (v.chk_res) chk("done_result", o_result, v.exp_res);
      @(negedge clk); i_dm_rdy = 1'b0;
    end else begin
      chk("alu_dst", {27'b0, o_dst_gpr}, {27'b0, v.exp_dst});
      chk("alu_result", o_result, v.exp_res);
      chk("alu_stall", {31'b0, o_mem_stall}, 32'd0);
      @(negedge clk); i_op = 6'h00; i_dst_gpr = 5'd0;
    end
  endtask

  initial begin
    nrst = 1'b0; i_exec_stall = 1'b0; i_fetch_stall = 1'b0;
    i_op = '0; i_dst_gpr = '0; i_result = '0; i_mem_data = '0;
    i_dm_ack = 1'b0; i_dm_rdy = 1'b0; i_dm_data = '0;

    vq.push_back(mk(6'h00, 5'd5,  32'h1234, 0, 0, 0, 0, 0, 0, 0, 5'd5, 32'h1234, 1));
    vq.push_back(mk(6'h20, 5'd7,  32'h103, 0, 32'h80AABBCC, 2, 3, 32'h100, 4'hF, 0, 5'd7,  32'hFFFFFF80, 1));
    vq.push_back(mk(6'h24, 5'd8,  32'h103, 0, 32'h80AABBCC, 0, 0, 32'h100, 4'hF, 0, 5'd8,  32'h00000080, 1));
    vq.push_back(mk(6'h25, 5'd9,  32'h102, 0, 32'h80AABBCC, 1, 1, 32'h100, 4'hF, 0, 5'd9,  32'h000080AA, 1));
    vq.push_back(mk(6'h21, 5'd10, 32'h102, 0, 32'h80AABBCC, 0, 2, 32'h100, 4'hF, 0, 5'd10, 32'hFFFF80AA, 1));
    vq.push_back(mk(6'h23, 5'd11, 32'h100, 0, 32'h80AABBCC, 1, 0, 32'h100, 4'hF, 0, 5'd11, 32'h80AABBCC, 1));
    vq.push_back(mk(6'h20, 5'd12, 32'h100, 0, 32'h80AABBCC, 0, 0, 32'h100, 4'hF, 0, 5'd12, 32'hFFFFFFCC, 1));
    vq.push_back(mk(6'h24, 5'd13, 32'h101, 0, 32'h80AABBCC, 0, 0, 32'h100, 4'hF, 0, 5'd13, 32'h000000BB, 1));
    vq.push_back(mk(6'h25, 5'd14, 32'h100, 0, 32'h80AABBCC, 0, 0, 32'h100, 4'hF, 0, 5'd14, 32'h0000BBCC, 1));
    vq.push_back(mk(6'h28, 5'd15, 32'h101, 32'h000000EE, 0, 1, 1, 32'h100, 4'b0010, 32'hEEEEEEEE, 5'd0, 0, 0));
    vq.push_back(mk(6'h28, 5'd15, 32'h103, 32'h12345677, 0, 0, 0, 32'h100, 4'b1000, 32'h77777777, 5'd0, 0, 0));
    vq.push_back(mk(6'h29, 5'd16, 32'h200, 32'hABCD1234, 0, 0, 1, 32'h200, 4'b0011, 32'h12341234, 5'd0, 0, 0));
    vq.push_back(mk(6'h2B, 5'd17, 32'h304, 32'hDEADBEEF, 0, 2, 0, 32'h304, 4'b1111, 32'hDEADBEEF, 5'd0, 0, 0));
    vq.push_back(mk(6'h01, 5'd0,  32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0, 5'd0, 32'hFFFFFFFF, 1));
`ifndef MEM_ALIGN_CHECK_EN
    vq.push_back(mk(6'h23, 5'd18, 32'h105, 0, 32'h80AABBCC, 0, 0, 32'h104, 4'hF, 0, 5'd18, 32'h80AABBCC, 1));
    vq.push_back(mk(6'h21, 5'd19, 32'h101, 0, 32'h80AABBCC, 0, 0, 32'h100, 4'hF, 0, 5'd19, 32'hFFFFBBCC, 1));
`endif

    #12;
    chk("rst_stall", {31'b0, o_mem_stall}, 32'd0);
    chk("rst_cmd", {31'b0, o_dm_cmd}, 32'd0);
    chk("rst_addr", o_dm_addr, 32'd0);
    chk("rst_dst", {27'b0, o_dst_gpr}, 32'd0);
    chk("rst_result", o_result, 32'd0);
    chk("rst_be", {28'b0, o_dm_be}, 32'd0);
    @(negedge clk); nrst = 1'b1;

    // Stalled IDLE must hold outputs.
    i_exec_stall = 1'b1;
    issue(6'h00, 5'd3, 32'hAAAA, 0);
    chk("exec_stall_dst", {27'b0, o_dst_gpr}, 32'd0);
    chk("exec_stall_res", o_result, 32'd0);
    @(negedge clk); i_exec_stall = 1'b0; i_fetch_stall = 1'b1;
    issue(6'h23, 5'd3, 32'h100, 0);
    chk("fetch_stall_cmd", {31'b0, o_dm_cmd}, 32'd0);
    chk("fetch_stall_ms", {31'b0, o_mem_stall}, 32'd0);
    @(negedge clk); i_fetch_stall = 1'b0; i_op = 6'h00; i_dst_gpr = 5'd0;

    foreach (vq[i]) run_vec(vq[i]);

    // SH with ack and rdy together in CMD: the rdy is not taken as data-phase completion.
    issue(6'h29, 5'd20, 32'h202, 32'h5678);
    chk("sh_be", {28'b0, o_dm_be}, 32'h0000000C);
    chk("sh_data", o_dm_data, 32'h56785678);
    @(negedge clk); i_op = 6'h00; i_dst_gpr = 5'd0; i_dm_ack = 1'b1; i_dm_rdy = 1'b1;
    @(posedge clk); #1;
    chk("sh_ackrdy_cmd", {31'b0, o_dm_cmd}, 32'd0);
    chk("sh_ackrdy_stall", {31'b0, o_mem_stall}, 32'd1);
    @(negedge clk); i_dm_ack = 1'b0; i_dm_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("sh_still_stall", {31'b0, o_mem_stall}, 32'd1);
    @(negedge clk); i_dm_rdy = 1'b1;
    @(posedge clk); #1;
    chk("sh_done_stall", {31'b0, o_mem_stall}, 32'd0);
    chk("sh_done_dst", {27'b0, o_dst_gpr}, 32'd0);
    @(negedge clk); i_dm_rdy = 1'b0;

    // Reset while the command is pending drops it immediately.
    issue(6'h23, 5'd21, 32'h400, 0);
    @(negedge clk); i_op = 6'h00; i_dst_gpr = 5'd0; nrst = 1'b0;
    #1;
    chk("rst_cmd_async", {31'b0, o_dm_cmd}, 32'd0);
    chk("rst_cmd_stall", {31'b0, o_mem_stall}, 32'd0);
    #2 nrst = 1'b1;

    // Reset in DATA; a late rdy must not produce a writeback.
    i_dm_data = 32'h13572468;
    issue(6'h23, 5'd22, 32'h500, 0);
    @(negedge clk); i_op = 6'h00; i_dst_gpr = 5'd0; i_dm_ack = 1'b1;
    @(posedge clk); #1;
    chk("pre_rst_data_stall", {31'b0, o_mem_stall}, 32'd1);
    @(negedge clk); i_dm_ack = 1'b0; nrst = 1'b0;
    #1;
    chk("rst_data_stall", {31'b0, o_mem_stall}, 32'd0);
    chk("rst_data_cmd", {31'b0, o_dm_cmd}, 32'd0);
    #2 nrst = 1'b1; i_exec_stall = 1'b1; i_op = 6'h00; i_dst_gpr = 5'd9;
    @(negedge clk); i_dm_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("late_rdy_dst", {27'b0, o_dst_gpr}, 32'd0);
    chk("late_rdy_res", o_result, 32'd0);
    chk("late_rdy_stall", {31'b0, o_mem_stall}, 32'd0);
    @(negedge clk); i_dm_rdy = 1'b0; i_exec_stall = 1'b0; i_dst_gpr = 5'd0;

`ifdef MEM_ALIGN_CHECK_EN
    issue(6'h23, 5'd23, 32'h102, 0);
    chk("align_err", {31'b0, o_addr_err}, 32'd1);
    chk("align_cmd", {31'b0, o_dm_cmd}, 32'd0);
    chk("align_stall", {31'b0, o_mem_stall}, 32'd0);
    chk("align_dst", {27'b0, o_dst_gpr}, 32'd0);
    @(negedge clk); i_op = 6'h00;
    @(posedge clk); #1;
    chk("align_err_pulse", {31'b0, o_addr_err}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/memory_access.md
Name: memory_access

Overview:
- CPU pipeline stage directly downstream of the execute stage.
- Consumes execute's registered op, destination register, ALU result (address or data) and store data.
- Performs loads and stores on the data-memory bus, with byte-lane steering and load sign/zero extension.
- Passes the register result to writeback and raises o_mem_stall while a bus access is outstanding.

Parameters:
- ADDR_WIDTH, 32, data bus address width (equals `CPU_ADDR_WIDTH).
- DATA_WIDTH, 32, data width (equals `CPU_DATA_WIDTH; only 32 supported).
- REGNO_WIDTH, 5, GPR index width.

Ports:
- clk  in  1  clock
- nrst  in  1  reset, asynchronous, active-low
- i_exec_stall  in  1  execute-stage stall
- i_fetch_stall  in  1  fetch-stage stall
- o_mem_stall  out  1  memory access in progress
- i_op  in  6  opcode from execute
- i_dst_gpr  in  REGNO_WIDTH  destination GPR from execute
- i_result  in  DATA_WIDTH  ALU result or effective address
- i_mem_data  in  DATA_WIDTH  store data (rt value)
- o_dm_addr  out  ADDR_WIDTH  data bus word address, bits[1:0]=0
- o_dm_rnw  out  1  1=read, 0=write
- o_dm_cmd  out  1  command valid
- i_dm_ack  in  1  command accepted
- o_dm_data  out  DATA_WIDTH  write data, lane-replicated
- o_dm_be  out  4  byte enables, bit n = byte lane n
- i_dm_rdy  in  1  read data valid / write done
- i_dm_data  in  DATA_WIDTH  read data
- o_dst_gpr  out  REGNO_WIDTH  writeback register; 0 = no write
- o_result  out  DATA_WIDTH  writeback value

Behaviour:
- Reset: all outputs 0; state IDLE.
- core_stall = i_exec_stall | i_fetch_stall | o_mem_stall.
- o_mem_stall is decoded from state only (no combinational path from inputs): high in CMD and DATA.
- FSM states IDLE, CMD, DATA.
- IDLE, !core_stall, non-memory op:
  - o_dst_gpr <= i_dst_gpr, o_result <= i_result; one-cycle latency.
- IDLE, !core_stall, memory op (LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2B):
  - latch op, dst, addr low bits, store data.
  - o_dst_gpr <= 0 (bubble), o_dm_cmd <= 1, o_dm_addr <= {i_result[31:2],2'b00}.
  - go to CMD.
- IDLE with core_stall: all outputs hold.
- CMD: hold o_dm_* stable until i_dm_ack. On ack: o_dm_cmd <= 0, go to DATA.
- DATA: wait for i_dm_rdy. i_dm_rdy is ignored outside DATA. On rdy:
  - load: o_dst_gpr <= latched dst, o_result <= formatted data.
  - store: o_dst_gpr <= 0.
  - go to IDLE.
  - The stage accepts the next instruction in the cycle after rdy.
- i_dm_ack and i_dm_rdy in the same cycle while in CMD: treated as ack only; rdy is required again in DATA.
- Store lanes:
  - SB: data = {4{byte}}, be = 1<<a[1:0].
  - SH: data = {2{half}}, be = a[1] ? 4'b1100 : 4'b0011.
  - SW: be = 4'b1111.
- Load lanes (little-endian):
  - LB/LBU: byte at lane a[1:0], sign-/zero-extended.
  - LH/LHU: half at a[1], sign-/zero-extended.
  - LW: whole word.
- Loads drive o_dm_be = 4'b1111.
- Reset mid-access: asynchronous return to IDLE, o_dm_cmd = 0 immediately; the in-flight bus response is discarded.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - Halfword access with a[0]=1, or word access with a[1:0]!=0, issues no bus command and stays in IDLE.
  - Sets o_dst_gpr <= 0 and pulses output o_addr_err (1 bit, present only when the macro is defined) for one cycle.
  - No stall.
- Undefined:
  - No o_addr_err port.
  - Misaligned low address bits are ignored for lane selection: halfword uses a[1], word uses lane 0.

Test Plan:
- ADDU result: i_op=0, i_dst_gpr=5, i_result=32'h1234 -> next cycle o_dst_gpr=5, o_result=32'h1234, o_mem_stall=0.
- LB at 32'h103, memory word 32'h80AABBCC:
  - o_dm_addr=32'h100, o_dm_rnw=1.
  - ack after 2 cycles, rdy after 3 more -> o_result=32'hFFFFFF80, o_dst_gpr=dst.
  - o_mem_stall high throughout.
- LHU at 32'h102, same word -> o_result=32'h000080AA.
- SB at 32'h101, i_mem_data=32'h000000EE -> o_dm_data=32'hEEEEEEEE, o_dm_be=4'b0010, o_dm_rnw=0, o_dst_gpr=0.
- SH at 32'h202, data 32'h5678 -> be=4'b1100, data=32'h56785678. Same-cycle ack and rdy in CMD -> stall persists until a second rdy.
- Reset asserted in DATA -> o_mem_stall=0 and o_dm_cmd=0 at once. A late i_dm_rdy causes no writeback (o_dst_gpr stays 0).
